tick_scheduler: RTL

- Shares one 100 MHz-derived prescaler (base tick) among NUM_CH independent timer channels.
- Each requester arms its channel with a tick count and gets a one-cycle expiry pulse; one-shot or periodic.
- Replaces per-client dividers for game timing: movement rate, stopwatch, blink.
- Everything runs in the clk100MHz domain; outputs are pulses/levels, never derived clocks.

---
 rtl/tick_scheduler.sv | 128 ++++++++++++
 1 files changed

// File: rtl/tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tick_scheduler
// Purpose  : One shared base-tick prescaler driving NUM_CH one-shot/periodic
//            timer channels with single-cycle expiry pulses.
// Option   : TICK_SCHEDULER_PAUSE_EN adds a 'pause' input that freezes all timing.
// Revision : 1.0 - initial release
// ============================================================================
module tick_scheduler #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int TICK_FREQ = 1000,
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                    clk100MHz,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       arm,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] period,
    input  logic [NUM_CH-1:0]       cancel,
`ifdef TICK_SCHEDULER_PAUSE_EN
    input  logic                    pause,
`endif
    output logic                    tick,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH-1:0]       expired
);

    localparam int PRESC = CLK_FREQ / TICK_FREQ;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [0:0] {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_t;

    logic [PW-1:0] presc_cnt;
    logic          hold;

`ifdef TICK_SCHEDULER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Free-running prescaler; tick is registered so it lands the cycle after the wrap.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            presc_cnt <= '0;
            tick      <= 1'b0;
        end else if (hold) begin
            tick      <= 1'b0;
        end else if (presc_cnt == PRESC_LAST) begin
            presc_cnt <= '0;
            tick      <= 1'b1;
        end else begin
            presc_cnt <= presc_cnt + PW'(1);
            tick      <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_state_t        state, state_nxt;
        logic [CNT_W-1:0] remaining, remaining_nxt;
        logic [CNT_W-1:0] per_lat, per_lat_nxt;
        logic [CNT_W-1:0] req_period;
        logic             mode_lat, mode_lat_nxt;
        logic             exp_r, exp_nxt;

        assign req_period = period[i*CNT_W +: CNT_W];

        always_ff @(posedge clk100MHz) begin
            if (rst) begin
                state     <= CH_IDLE;
                remaining <= '0;
                per_lat   <= '0;
                mode_lat  <= 1'b0;
                exp_r     <= 1'b0;
            end else begin
                state     <= state_nxt;
                remaining <= remaining_nxt;
                per_lat   <= per_lat_nxt;
                mode_lat  <= mode_lat_nxt;
                exp_r     <= exp_nxt;
            end
        end

        // Priority per cycle: cancel, then arm (restart), then base tick.
        always_comb begin
            state_nxt     = state;
            remaining_nxt = remaining;
            per_lat_nxt   = per_lat;
            mode_lat_nxt  = mode_lat;
            exp_nxt       = 1'b0;
            if (cancel[i]) begin
                state_nxt = CH_IDLE;
            end else if (arm[i]) begin
                if (req_period != '0) begin
                    per_lat_nxt   = req_period;
                    mode_lat_nxt  = periodic[i];
                    remaining_nxt = req_period;
                    state_nxt     = CH_RUN;
                end else begin
                    exp_nxt   = 1'b1;
                    state_nxt = CH_IDLE;
                end
            end else if (state == CH_RUN && tick) begin
                if (remaining > CNT_ONE) begin
                    remaining_nxt = remaining - CNT_ONE;
                end else begin
                    exp_nxt = 1'b1;
                    if (mode_lat) begin
                        remaining_nxt = per_lat;
                    end else begin
                        state_nxt = CH_IDLE;
                    end
                end
            end
        end

        assign busy[i]    = (state == CH_RUN);
        assign expired[i] = exp_r;
    end

endmodule
`default_nettype wire
